// File: rtl/pixel_unpacker_if.sv
// pixel_unpacker_if
// Packed 32-bit AXI4-Stream video bus carrying 4 x 24-bit pixels in 3 words.
//   tdata  : packed pixel bytes, little-endian
//   tkeep  : byte enables (sinks ignore it, sources drive 4'hF)
//   tlast  : last word of a line
//   tuser  : first word of a frame
//   tvalid : word valid (source)
//   tready : word accepted when tvalid & tready (sink)
// Modports: master = stream source, slave = stream sink.
interface pixel_unpacker_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/pixel_unpacker.sv
// pixel_unpacker
// AXI4-Stream video sink: unpacks 3 packed 32-bit words into 4 {r,g,b} pixels,
// emitting one pixel per downstream handshake with x/y coordinates, SOF/EOL
// flags and framing-error pulses.
// Parameters: X_SIZE (pixels per line, multiple of 4), Y_SIZE (lines per frame).
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   in_stream (slave)    packed word stream (tdata/tkeep/tlast/tuser/tvalid/tready)
//   r, g, b              pixel channels
//   x, y                 pixel column / row
//   sof, eol             pixel is (0,0) / pixel closes its line
//   valid, ready         pixel handshake
//   eol_err, sof_err     one-cycle framing-error pulses
// Optional: define UNPACK_STATS_EN to add saturating counters
//   frame_count[15:0], err_count[15:0], lines_rx[9:0].
module pixel_unpacker #(
    parameter int X_SIZE = 1280,
    parameter int Y_SIZE = 720
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    pixel_unpacker_if.slave      in_stream,
    output logic [7:0]           r,
    output logic [7:0]           g,
    output logic [7:0]           b,
    output logic [10:0]          x,
    output logic [9:0]           y,
    output logic                 sof,
    output logic                 eol,
    output logic                 valid,
    input  logic                 ready,
    output logic                 eol_err,
    output logic                 sof_err
`ifdef UNPACK_STATS_EN
    ,
    output logic [15:0]          frame_count,
    output logic [15:0]          err_count,
    output logic [9:0]           lines_rx
`endif
);
    localparam int              WPL     = 3 * X_SIZE / 4;
    localparam int              WI_W    = $clog2(WPL);
    localparam logic [WI_W-1:0] WI_LAST = WI_W'(WPL - 1);
    localparam logic [10:0]     X_LAST  = 11'(X_SIZE - 1);
    localparam logic [9:0]      Y_LAST  = 10'(Y_SIZE - 1);

    typedef enum logic [1:0] {W0, W1, W2, EMIT3} state_t;

    state_t          r_state, w_state_d, w_st;
    logic [23:0]     r_hold, w_hold_d, w_pix;
    logic [WI_W-1:0] r_wi, w_wi_d, w_wi;
    logic [10:0]     r_cx, w_cx_d, w_px;
    logic [9:0]      r_cy, w_cy_d, w_py;
    logic            w_adv, w_acc, w_emit, w_resync, w_early, w_miss;
    logic            w_pix_sof, w_pix_eol;
    logic            w_unused;

    assign w_unused = &{1'b0, in_stream.tkeep};

    // Output register can take a new pixel when empty or being drained.
    assign w_adv  = ~valid | ready;
    assign in_stream.tready = aresetn & (r_state != EMIT3) & w_adv;
    assign w_acc  = in_stream.tvalid & in_stream.tready;
    assign w_emit = w_acc | ((r_state == EMIT3) & w_adv);

    // tuser anywhere but the frame origin restarts decoding as w0 of a new frame.
    assign w_resync = w_acc & in_stream.tuser & ((r_state != W0) | (r_cx != '0) | (r_cy != '0));

    // Effective decode context after a possible resync.
    assign w_st = w_resync ? W0 : r_state;
    assign w_wi = w_resync ? '0 : r_wi;
    assign w_px = w_resync ? '0 : r_cx;
    assign w_py = w_resync ? '0 : r_cy;

    assign w_early   = w_acc & in_stream.tlast & (w_wi != WI_LAST);
    assign w_miss    = w_acc & ~in_stream.tlast & (w_wi == WI_LAST);
    assign w_pix_sof = (w_px == '0) & (w_py == '0);
    assign w_pix_eol = w_early | (w_px == X_LAST);

    // Byte splicing: r_hold carries the bytes left over from the previous word.
    always_comb begin
        w_pix    = r_hold;
        w_hold_d = r_hold;
        case (w_st)
            W0: begin
                w_pix    = in_stream.tdata[23:0];
                w_hold_d = {16'h0, in_stream.tdata[31:24]};
            end
            W1: begin
                w_pix    = {in_stream.tdata[15:0], r_hold[7:0]};
                w_hold_d = {8'h0, in_stream.tdata[31:16]};
            end
            W2: begin
                w_pix    = {in_stream.tdata[7:0], r_hold[15:0]};
                w_hold_d = in_stream.tdata[31:8];
            end
            default: begin
                w_pix    = r_hold;
                w_hold_d = r_hold;
            end
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_wi_d    = r_wi;
        w_cx_d    = r_cx;
        w_cy_d    = r_cy;
        if (w_emit) begin
            if (w_early) begin
                w_state_d = W0;
            end else begin
                case (w_st)
                    W0:      w_state_d = W1;
                    W1:      w_state_d = W2;
                    W2:      w_state_d = EMIT3;
                    default: w_state_d = W0;
                endcase
            end
            if (w_acc)
                w_wi_d = (w_early | (w_wi == WI_LAST)) ? '0 : w_wi + 1'b1;
            if (w_pix_eol) begin
                w_cx_d = '0;
                w_cy_d = (w_py == Y_LAST) ? '0 : w_py + 1'b1;
            end else begin
                w_cx_d = w_px + 1'b1;
                w_cy_d = w_py;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= W0;
            r_hold  <= '0;
            r_wi    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            r_state <= w_state_d;
            r_wi    <= w_wi_d;
            r_cx    <= w_cx_d;
            r_cy    <= w_cy_d;
            if (w_emit)
                r_hold <= w_hold_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid     <= 1'b0;
            {r, g, b} <= '0;
            x         <= '0;
            y         <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eol_err   <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            eol_err <= w_early | w_miss;
            sof_err <= w_resync;
            if (w_emit) begin
                valid     <= 1'b1;
                {r, g, b} <= w_pix;
                x         <= w_px;
                y         <= w_py;
                sof       <= w_pix_sof;
                eol       <= w_pix_eol;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef UNPACK_STATS_EN
    logic [9:0] w_lines_base;
    assign w_lines_base = w_pix_sof ? '0 : lines_rx;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count <= '0;
            err_count   <= '0;
            lines_rx    <= '0;
        end else begin
            if (w_emit & (w_px == X_LAST) & (w_py == Y_LAST) & (frame_count != '1))
                frame_count <= frame_count + 1'b1;
            // Simultaneous eol/sof errors count once.
            if ((w_early | w_miss | w_resync) & (err_count != '1))
                err_count <= err_count + 1'b1;
            if (w_emit)
                lines_rx <= w_lines_base + 10'((w_pix_eol & (w_lines_base != '1)) ? 1 : 0);
        end
    end
`endif
endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker
// Random packed-word stimulus against a byte-queue reference model: every
// accepted word pushes 4 bytes, pixels are popped 3 bytes at a time, and
// framing rules (early/missing tlast, resync on tuser) act on the queue and
// on plain x/y/word counters.
module tb_pixel_unpacker;
    localparam int X   = 16;
    localparam int Y   = 4;
    localparam int WPL = 3 * X / 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  r, g, b;
    logic [10:0] x;
    logic [9:0]  y;
    logic        sof, eol, valid, eol_err, sof_err;
`ifdef UNPACK_STATS_EN
    logic [15:0] frame_count, err_count;
    logic [9:0]  lines_rx;
`endif

    pixel_unpacker_if s_if ();

    pixel_unpacker #(.X_SIZE(X), .Y_SIZE(Y)) dut (
        .aclk(aclk), .aresetn(aresetn), .in_stream(s_if),
        .r(r), .g(g), .b(b), .x(x), .y(y), .sof(sof), .eol(eol),
        .valid(valid), .ready(ready), .eol_err(eol_err), .sof_err(sof_err)
`ifdef UNPACK_STATS_EN
        , .frame_count(frame_count), .err_count(err_count), .lines_rx(lines_rx)
`endif
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [23:0] pix;
        int          x, y;
        bit          sof, eol, ee, se;
    } exp_t;

    logic [7:0] bq[$];
    exp_t       exq[$];
    int mx = 0, my = 0, mwi = 0;
    int m_frames = 0, m_errs = 0, m_lines = 0;

    function automatic void m_emit(bit feol, bit ee, bit se);
        exp_t e;
        e.pix = {bq[2], bq[1], bq[0]};
        repeat (3) void'(bq.pop_front());
        e.x = mx; e.y = my;
        e.sof = (mx == 0 && my == 0);
        e.eol = feol || (mx == X - 1);
        e.ee = ee; e.se = se;
        exq.push_back(e);
        if (ee || se) m_errs++;
        if (mx == X - 1 && my == Y - 1) m_frames++;
        if (e.sof) m_lines = 0;
        if (e.eol) m_lines++;
        if (!feol) begin
            if (mx == X - 1) begin mx = 0; my = (my + 1) % Y; end
            else mx++;
        end
    endfunction

    function automatic void m_push(logic [31:0] d, bit user, bit last);
        bit se, early, miss;
        se = user && (bq.size() != 0 || mx != 0 || my != 0);
        if (se) begin bq.delete(); mx = 0; my = 0; mwi = 0; end
        for (int i = 0; i < 4; i++) bq.push_back(d[8*i +: 8]);
        early = last && (mwi < WPL - 1);
        miss  = !last && (mwi == WPL - 1);
        m_emit(early, early || miss, se);
        if (early) begin
            bq.delete(); mx = 0; my = (my + 1) % Y; mwi = 0;
        end else begin
            mwi = (mwi == WPL - 1) ? 0 : mwi + 1;
            if (bq.size() >= 3) m_emit(1'b0, 1'b0, 1'b0);
        end
    endfunction

    // ---------------- ready generator / monitor ----------------
    int  rdy_mode = 1;   // 0 low, 1 high, 2 random
    int  cyc = 0;
    int  pix_cnt = 0, first_cyc = 0, last_cyc = 0;
    bit  pend_e = 0, pend_s = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (rdy_mode == 1) ready = 1'b1;
        else if (rdy_mode == 2) ready = 1'($urandom_range(0, 1));
        else ready = 1'b0;
    end

    always @(negedge aclk) begin
        #2;
        if (aresetn) begin
            pend_e = pend_e | eol_err;
            pend_s = pend_s | sof_err;
            if (valid && !ready) chk("tready_bp", s_if.tready, 0);
            if (valid && ready) begin
                if (exq.size() == 0) chk("unexp_pix", valid, 0);
                else begin
                    exp_t e;
                    e = exq.pop_front();
                    chk("pix", {r, g, b}, e.pix);
                    chk("x", x, e.x);
                    chk("y", y, e.y);
                    chk("sof", sof, e.sof);
                    chk("eol", eol, e.eol);
                    chk("eol_err", pend_e, e.ee);
                    chk("sof_err", pend_s, e.se);
                end
                pend_e = 0; pend_s = 0;
                if (pix_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                pix_cnt++;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_word(input logic [31:0] d, input bit user, input bit last);
        bit got = 0;
        m_push(d, user, last);
        @(negedge aclk);
        s_if.tdata = d; s_if.tuser = user; s_if.tlast = last; s_if.tvalid = 1'b1;
        for (int i = 0; i < 500 && !got; i++) begin
            #1;
            if (s_if.tready) begin @(posedge aclk); got = 1; end
            else @(negedge aclk);
        end
        chk("accept_timeout", got, 1);
        #1 s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    endtask

    task automatic send_line(input bit user, input int nw, input bit last);
        for (int i = 0; i < nw; i++)
            send_word($urandom, user && i == 0, last && i == nw - 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exq.size() != 0; i++) @(negedge aclk);
        chk("drain_left", exq.size(), 0);
        repeat (2) @(negedge aclk);
    endtask

    task automatic model_reset();
        bq.delete(); exq.delete();
        mx = 0; my = 0; mwi = 0;
        m_frames = 0; m_errs = 0; m_lines = 0;
        pend_e = 0; pend_s = 0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_tready"}, s_if.tready, 0);
        chk({tag, "_rgb"}, {r, g, b}, 0);
        chk({tag, "_xy"}, {x, y}, 0);
        chk({tag, "_flags"}, {sof, eol, eol_err, sof_err}, 0);
`ifdef UNPACK_STATS_EN
        chk({tag, "_stats"}, {frame_count, err_count}, 0);
        chk({tag, "_lines"}, lines_rx, 0);
`endif
    endtask

    task automatic chk_stats();
`ifdef UNPACK_STATS_EN
        chk("frame_count", frame_count, m_frames);
        chk("err_count", err_count, m_errs);
        chk("lines_rx", lines_rx, m_lines);
`endif
    endtask

    initial begin
        s_if.tdata = '0; s_if.tkeep = 4'hF; s_if.tlast = 0; s_if.tuser = 0; s_if.tvalid = 0;
        repeat (3) @(negedge aclk);
        #2 chk_idle_outputs("rst");
        @(negedge aclk);
        aresetn = 1'b1;
        #1 chk("tready_release", s_if.tready, 1);

        // Directed first words, then finish the frame.
        send_word(32'h44332211, 1, 0);
        send_word(32'h77665544, 0, 0);
        send_word(32'hAABB9988, 0, 0);
        send_line(0, WPL - 3, 1);
        for (int l = 1; l < Y; l++) send_line(0, WPL, 1);
        drain();

        // Full frame at full rate: one pixel per cycle.
        pix_cnt = 0;
        for (int l = 0; l < Y; l++) send_line(l == 0, WPL, 1);
        drain();
        chk("frame_pix", pix_cnt, X * Y);
        chk("throughput", last_cyc - first_cyc + 1, X * Y);
        chk_stats();

        // Random backpressure over one line.
        rdy_mode = 2;
        send_line(1, WPL, 1);
        // Early tlast at word 5, missing tlast, normal line.
        send_line(0, 6, 1);
        send_line(0, WPL, 0);
        send_line(0, WPL, 1);
        // tuser on w1 at x=1 resyncs.
        send_word($urandom, 1, 0);
        send_word($urandom, 1, 0);
        send_line(0, WPL - 1, 1);
        // tuser and tlast on the same mid-line word.
        send_word($urandom, 0, 0);
        send_word($urandom, 1, 1);
        send_line(0, WPL, 1);
        rdy_mode = 1;
        drain();
        chk_stats();

        // Reset while stalled in EMIT3.
        send_word($urandom, 0, 0);
        send_word($urandom, 0, 0);
        send_word($urandom, 0, 0);
        rdy_mode = 0; ready = 1'b0;
        #1 chk("e3_valid", valid, 1);
        chk("e3_tready", s_if.tready, 0);
        aresetn = 1'b0;
        model_reset();
        #1 chk_idle_outputs("mid_rst");
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        rdy_mode = 1;
        send_line(1, WPL, 1);
        drain();
        chk_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
